// File: rtl/fft_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// fft_frame_ctrl_if
// Bundles the sample handshake, the FFT input stream and the result-tracking
// flags of fft_frame_ctrl.
//   in_valid/in_ready/in_re/in_im  : upstream sample handshake (signed DW bits)
//   fft_in_re/fft_in_im            : samples streamed to the FFT core
//   fft_in_valid/frame_start       : streaming window and sample-0 marker
//   out_valid/out_idx/frame_done   : FFT result-pair window, index, last pair
//   busy                           : frames buffered, streaming or pending
// master = sample source / observer, slave = fft_frame_ctrl.
// ---------------------------------------------------------------------------
interface fft_frame_ctrl_if #(
    parameter int DW = 9
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;
    logic signed [DW-1:0] fft_in_re;
    logic signed [DW-1:0] fft_in_im;
    logic                 fft_in_valid;
    logic                 frame_start;
    logic                 out_valid;
    logic [3:0]           out_idx;
    logic                 frame_done;
    logic                 busy;

    modport master (
        output in_valid, in_re, in_im,
        input  in_ready, fft_in_re, fft_in_im, fft_in_valid, frame_start,
        input  out_valid, out_idx, frame_done, busy
    );

    modport slave (
        input  in_valid, in_re, in_im,
        output in_ready, fft_in_re, fft_in_im, fft_in_valid, frame_start,
        output out_valid, out_idx, frame_done, busy
    );
endinterface

// File: rtl/fft_frame_ctrl.sv
// ---------------------------------------------------------------------------
// fft_frame_ctrl
// Frame sequencer in front of a 32-point MDC FFT core. Samples are collected
// into a two-bank ping-pong store; each full bank is streamed to the FFT as
// 32 contiguous cycles (the MDC pipeline cannot stall). A LATENCY-deep marker
// pipeline then flags the 16 result-pair cycles with an index and frame_done.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fft_frame_ctrl_if.slave (handshake, FFT stream, result flags)
// All outputs are registered.
// ---------------------------------------------------------------------------
module fft_frame_ctrl #(
    parameter int N       = 32,
    parameter int DW      = 9,
    parameter int LATENCY = 40
) (
    input  logic            clk,
    input  logic            rst_n,
    fft_frame_ctrl_if.slave bus
);
    localparam int             AW        = $clog2(N);
    localparam logic [AW-1:0]  LAST_IDX  = AW'(N - 1);
    localparam logic [AW-1:0]  ONE       = AW'(1);
    localparam logic [3:0]     LAST_PAIR = 4'(N / 2 - 1);

    typedef enum logic [0:0] {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    // Frame store: {re, im} per entry
    logic [2*DW-1:0]      bank_mem_q [0:1][0:N-1];

    // Write side
    logic [1:0]           full_q, full_d;
    logic                 wr_bank_q, wr_bank_d;
    logic [AW-1:0]        wr_cnt_q, wr_cnt_d;
    logic                 in_ready_q, in_ready_d;
    logic                 accept_s;
    logic                 wr_done_s;

    // Read side
    rd_state_e            state_q, state_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [AW-1:0]        rd_cnt_q, rd_cnt_d;
    logic                 emit_s;
    logic [AW-1:0]        rd_idx_s;
    logic                 rd_done_s;
    logic [2*DW-1:0]      rd_word_s;

    // FFT input stream registers
    logic signed [DW-1:0] fft_re_q, fft_re_d;
    logic signed [DW-1:0] fft_im_q, fft_im_d;
    logic                 fft_valid_q, fft_valid_d;
    logic                 frame_start_q, frame_start_d;

    // Result tracking
    logic [LATENCY-1:0]   marker_q, marker_d;
    logic                 marker_exit_s;
    logic                 out_valid_q, out_valid_d;
    logic [3:0]           out_idx_q, out_idx_d;
    logic                 frame_done_q, frame_done_d;
    logic                 busy_q, busy_d;

    // Write counter / bank selection for accepted samples
    always_comb begin
        accept_s  = bus.in_valid & in_ready_q;
        wr_done_s = 1'b0;
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        if (accept_s) begin
            if (wr_cnt_q == LAST_IDX) begin
                wr_done_s = 1'b1;
                wr_cnt_d  = '0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                wr_cnt_d  = wr_cnt_q + ONE;
            end
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
    end

    // Bank-full flags: read frees rd_bank, write fills wr_bank (never the same bank)
    always_comb begin
        full_d = full_q;
        if (rd_done_s) begin
            full_d[rd_bank_q] = 1'b0;
        end else begin
            full_d[rd_bank_q] = full_q[rd_bank_q];
        end
        if (wr_done_s) begin
            full_d[wr_bank_q] = 1'b1;
        end else begin
            full_d[wr_bank_q] = full_d[wr_bank_q];
        end
        // Registered ready looks at the bank that will be written next cycle,
        // so it only drops when both banks hold unread frames.
        in_ready_d = ~full_d[wr_bank_d];
    end

    // Sample storage (no reset: contents are qualified by the full flags)
    always_ff @(posedge clk) begin
        if (accept_s) begin
            bank_mem_q[wr_bank_q][wr_cnt_q] <= {bus.in_re, bus.in_im};
        end
    end

    // Read FSM: IDLE pre-loads sample 0 as soon as rd_bank fills, so the
    // stream register presents it two cycles after the 32nd accept.
    // rd_cnt_q holds the index of the next sample to be loaded.
    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rd_cnt_d  = rd_cnt_q;
        emit_s    = 1'b0;
        rd_idx_s  = rd_cnt_q;
        rd_done_s = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    emit_s   = 1'b1;
                    rd_idx_s = '0;
                    rd_cnt_d = ONE;
                    state_d  = RD_STREAM;
                end else begin
                    rd_cnt_d = '0;
                    state_d  = RD_IDLE;
                end
            end
            RD_STREAM: begin
                emit_s   = 1'b1;
                rd_idx_s = rd_cnt_q;
                if (rd_cnt_q == LAST_IDX) begin
                    rd_done_s = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    rd_cnt_d  = '0;
                    // Other bank already full: continue with no gap
                    if (full_q[~rd_bank_q]) begin
                        state_d = RD_STREAM;
                    end else begin
                        state_d = RD_IDLE;
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + ONE;
                    state_d  = RD_STREAM;
                end
            end
            default: begin
                state_d  = RD_IDLE;
                rd_cnt_d = '0;
            end
        endcase
    end

    // Stream datapath: selected word, or zeros outside streaming
    always_comb begin
        rd_word_s = bank_mem_q[rd_bank_q][rd_idx_s];
        if (emit_s) begin
            fft_re_d      = rd_word_s[2*DW-1:DW];
            fft_im_d      = rd_word_s[DW-1:0];
            fft_valid_d   = 1'b1;
            frame_start_d = (rd_idx_s == '0);
        end else begin
            fft_re_d      = '0;
            fft_im_d      = '0;
            fft_valid_d   = 1'b0;
            frame_start_d = 1'b0;
        end
    end

    // Marker delay line: bit k is high k+1 cycles after frame_start is loaded
    always_comb begin
        marker_d    = '0;
        marker_d[0] = frame_start_d;
        for (int i = 1; i < LATENCY; i++) begin
            marker_d[i] = marker_q[i-1];
        end
        marker_exit_s = marker_q[LATENCY-1];
    end

    // Result window: 16 pairs after the marker leaves the delay line
    always_comb begin
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        if (marker_exit_s) begin
            out_valid_d = 1'b1;
            out_idx_d   = 4'd0;
        end else if (out_valid_q) begin
            if (out_idx_q == LAST_PAIR) begin
                out_valid_d = 1'b0;
                out_idx_d   = 4'd0;
            end else begin
                out_idx_d   = out_idx_q + 4'd1;
            end
        end else begin
            out_valid_d = 1'b0;
            out_idx_d   = 4'd0;
        end
        frame_done_d = out_valid_d & (out_idx_d == LAST_PAIR);
        busy_d       = (|full_d) | fft_valid_d | (|marker_d) | out_valid_d;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q        <= 2'b00;
            wr_bank_q     <= 1'b0;
            wr_cnt_q      <= '0;
            in_ready_q    <= 1'b1;
            state_q       <= RD_IDLE;
            rd_bank_q     <= 1'b0;
            rd_cnt_q      <= '0;
            fft_re_q      <= '0;
            fft_im_q      <= '0;
            fft_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            marker_q      <= '0;
            out_valid_q   <= 1'b0;
            out_idx_q     <= 4'd0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            full_q        <= full_d;
            wr_bank_q     <= wr_bank_d;
            wr_cnt_q      <= wr_cnt_d;
            in_ready_q    <= in_ready_d;
            state_q       <= state_d;
            rd_bank_q     <= rd_bank_d;
            rd_cnt_q      <= rd_cnt_d;
            fft_re_q      <= fft_re_d;
            fft_im_q      <= fft_im_d;
            fft_valid_q   <= fft_valid_d;
            frame_start_q <= frame_start_d;
            marker_q      <= marker_d;
            out_valid_q   <= out_valid_d;
            out_idx_q     <= out_idx_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.fft_in_re    = fft_re_q;
    assign bus.fft_in_im    = fft_im_q;
    assign bus.fft_in_valid = fft_valid_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_idx      = out_idx_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_ctrl
// Scenario table plus per-cycle reference model for fft_frame_ctrl. The
// model keeps a list of completed frames with their completion cycle and
// predicted stream start; all expected outputs are derived from that list.
// ---------------------------------------------------------------------------
module tb_fft_frame_ctrl;
    localparam int DW  = 9;
    localparam int LAT = 40;
    localparam int NPT = 32;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fft_frame_ctrl_if #(.DW(DW)) bus();

    fft_frame_ctrl #(.N(NPT), .DW(DW), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int   mode;        // 0 ramp every cycle, 1 every other cycle, 2 random 50%, 3 random 80%
        int   nsamp;
        int   exp_frames;
        logic exp_ready;
        logic exp_busy;
    } vec_t;

    vec_t tbl [6];

    int total = 0;
    int bad   = 0;

    // reference model state
    int          fr_start   [0:63];
    int          fr_cmpl    [0:63];
    logic [17:0] samp       [0:2047];
    int          nacc;
    int          nfr;

    // observations
    int obs_fs, obs_fd, obs_ov, obs_fv;
    int first_fv, last_fv, first_ov, first_fs, last_acc;

    task automatic chk(input string name, input int cyc, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // frames whose bank is occupied during cycle c
    function automatic int held_at(input int c);
        int h = 0;
        for (int f = 0; f < nfr; f++) begin
            if (fr_cmpl[f] < c && c <= fr_start[f] + NPT - 2) h++;
        end
        return h;
    endfunction

    function automatic int ready_at(input int c);
        return (held_at(c) < 2) ? 1 : 0;
    endfunction

    task automatic check_cycle(input int c);
        int          e_fv, e_fs, e_ov, e_fd, e_busy, e_idx, k;
        logic [17:0] e_word;
        e_fv = 0; e_fs = 0; e_ov = 0; e_fd = 0; e_idx = 0;
        e_word = '0;
        e_busy = (held_at(c) > 0) ? 1 : 0;
        for (int f = 0; f < nfr; f++) begin
            if (c >= fr_start[f] && c <= fr_start[f] + NPT - 1) begin
                e_fv   = 1;
                k      = c - fr_start[f];
                e_word = samp[f*NPT + k];
                e_fs   = (k == 0) ? 1 : 0;
            end
            if (c >= fr_start[f] && c <= fr_start[f] + LAT + 15) e_busy = 1;
            if (c >= fr_start[f] + LAT && c <= fr_start[f] + LAT + 15) begin
                e_ov  = 1;
                e_idx = c - fr_start[f] - LAT;
                e_fd  = (e_idx == 15) ? 1 : 0;
            end
        end
        chk("in_ready",     c, int'(bus.in_ready),     ready_at(c));
        chk("fft_in_valid", c, int'(bus.fft_in_valid), e_fv);
        chk("fft_in_data",  c, int'({bus.fft_in_re, bus.fft_in_im}), int'(e_word));
        chk("frame_start",  c, int'(bus.frame_start),  e_fs);
        chk("out_valid",    c, int'(bus.out_valid),    e_ov);
        chk("out_idx",      c, int'(bus.out_idx),      e_idx);
        chk("frame_done",   c, int'(bus.frame_done),   e_fd);
        chk("busy",         c, int'(bus.busy),         e_busy);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},     -1, int'(bus.in_ready),     1);
        chk({tag, "_fft_in_valid"}, -1, int'(bus.fft_in_valid), 0);
        chk({tag, "_fft_in_data"},  -1, int'({bus.fft_in_re, bus.fft_in_im}), 0);
        chk({tag, "_frame_start"},  -1, int'(bus.frame_start),  0);
        chk({tag, "_out_valid"},    -1, int'(bus.out_valid),    0);
        chk({tag, "_out_idx"},      -1, int'(bus.out_idx),      0);
        chk({tag, "_frame_done"},   -1, int'(bus.frame_done),   0);
        chk({tag, "_busy"},         -1, int'(bus.busy),         0);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_re    = '0;
        bus.in_im    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
    endtask

    // Runs one scenario; cycle 0 is the cycle right after reset release.
    task automatic run(input int mode, input int nsamp, input bit with_reset);
        int         c;
        bit         done;
        bit         v;
        logic [8:0] r, m;
        int         st;
        if (with_reset) do_reset();
        nacc = 0; nfr = 0;
        obs_fs = 0; obs_fd = 0; obs_ov = 0; obs_fv = 0;
        first_fv = -1; last_fv = -1; first_ov = -1; first_fs = -1; last_acc = -1;
        c = 0;
        done = 1'b0;
        while (!done) begin
            v = 1'b0;
            if (nacc < nsamp) begin
                case (mode)
                    0:       v = 1'b1;
                    1:       v = (c % 2 == 0);
                    2:       v = ($urandom_range(0, 1) == 1);
                    default: v = ($urandom_range(0, 4) != 0);
                endcase
            end
            if (mode == 0) begin
                r = 9'(nacc);
                m = 9'(-nacc);
            end else begin
                r = 9'($urandom);
                m = 9'($urandom);
            end
            bus.in_valid = v;
            bus.in_re    = r;
            bus.in_im    = m;
            @(negedge clk);
            check_cycle(c);
            if (bus.frame_start) begin
                obs_fs++;
                if (first_fs < 0) first_fs = c;
            end
            if (bus.frame_done) obs_fd++;
            if (bus.out_valid) begin
                obs_ov++;
                if (first_ov < 0) first_ov = c;
            end
            if (bus.fft_in_valid) begin
                obs_fv++;
                if (first_fv < 0) first_fv = c;
                last_fv = c;
            end
            if (v && ready_at(c) == 1) begin
                samp[nacc] = {r, m};
                nacc++;
                last_acc = c;
                if (nacc % NPT == 0) begin
                    st = c + 2;
                    if (nfr > 0 && fr_start[nfr-1] + NPT > st) st = fr_start[nfr-1] + NPT;
                    fr_cmpl[nfr]  = c;
                    fr_start[nfr] = st;
                    nfr++;
                end
            end
            @(posedge clk);
            #1;
            c++;
            if (nacc == nsamp && c > last_acc + 4 && (nfr == 0 || c > fr_start[nfr-1] + LAT + 20))
                done = 1'b1;
            if (c >= 4000) begin
                total++;
                bad++;
                $display("FAIL cycle_budget cycle=%0d accepted=%0d required=%0d", c, nacc, nsamp);
                done = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int w;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_re    = '0;
        bus.in_im    = '0;

        tbl[0] = '{0,  32, 1, 1'b1, 1'b0};   // single frame, ramp data
        tbl[1] = '{0,  96, 3, 1'b1, 1'b0};   // back-to-back
        tbl[2] = '{1,  64, 2, 1'b1, 1'b0};   // gapped input
        tbl[3] = '{0,  20, 0, 1'b1, 1'b0};   // partial frame
        tbl[4] = '{2,  96, 3, 1'b1, 1'b0};   // random 50%
        tbl[5] = '{3, 160, 5, 1'b1, 1'b0};   // random 80%

        for (int i = 0; i < 6; i++) begin
            run(tbl[i].mode, tbl[i].nsamp, 1'b1);
            chk("frames_streamed",  i, obs_fs, tbl[i].exp_frames);
            chk("frames_done",      i, obs_fd, tbl[i].exp_frames);
            chk("out_valid_cycles", i, obs_ov, 16 * tbl[i].exp_frames);
            chk("stream_cycles",    i, obs_fv, NPT * tbl[i].exp_frames);
            chk("ready_at_end",     i, int'(bus.in_ready), int'(tbl[i].exp_ready));
            chk("busy_at_end",      i, int'(bus.busy),     int'(tbl[i].exp_busy));
            if (i == 0) begin
                chk("stream_latency", i, first_fv - last_acc, 2);
                chk("result_latency", i, first_ov - first_fs, LAT);
            end
            if (i == 1) begin
                chk("contiguous_span", i, last_fv - first_fv + 1, 3 * NPT);
            end
        end

        // Reset while a frame is streaming
        do_reset();
        for (int k = 0; k < NPT; k++) begin
            bus.in_valid = 1'b1;
            bus.in_re    = 9'(k);
            bus.in_im    = 9'(-k);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        w = 0;
        while (!bus.frame_start && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("abort_frame_started", w, int'(bus.frame_start), 1);
        repeat (10) @(posedge clk);
        #2;
        chk("abort_streaming_before_reset", -1, int'(bus.fft_in_valid), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(0, NPT, 1'b0);
        chk("after_abort_frames",    -1, obs_fs, 1);
        chk("after_abort_out_valid", -1, obs_ov, 16);
        chk("after_abort_latency",   -1, first_fv - last_acc, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
